// File: rtl/caravel_counter_timer_pkg.sv
// Shared constants for the caravel counter/timer peripheral:
// config bit positions and register widths.
package caravel_counter_timer_pkg;

    localparam int REG_W = 32;
    localparam int CFG_W = 5;

    localparam int CFG_EN      = 0;
    localparam int CFG_ONESHOT = 1;
    localparam int CFG_UPDOWN  = 2;
    localparam int CFG_CHAIN   = 3;
    localparam int CFG_IRQEN   = 4;

endpackage

// File: rtl/caravel_counter_timer.sv
// 32-bit up/down, one-shot/continuous counter/timer with chaining.
// Ports: clkin/resetn (async active-low), byte-strobed count (reg_val_*),
// data (reg_dat_*) and config (reg_cfg_*) registers, chain_in tick from a
// lower timer, term_out terminal pulse, irq_out level interrupt.
// Macro COUNTER_TIMER_IRQ_EN: adds irq_out, the irq flag and config bit 4.
module caravel_counter_timer
    import caravel_counter_timer_pkg::*;
(
    input  logic             clkin,
    input  logic             resetn,
    input  logic [3:0]       reg_val_we,
    input  logic [REG_W-1:0] reg_val_di,
    output logic [REG_W-1:0] reg_val_do,
    input  logic [3:0]       reg_dat_we,
    input  logic [REG_W-1:0] reg_dat_di,
    output logic [REG_W-1:0] reg_dat_do,
    input  logic             reg_cfg_we,
    input  logic [CFG_W-1:0] reg_cfg_di,
    output logic [CFG_W-1:0] reg_cfg_do,
    input  logic             chain_in,
    output logic             term_out
`ifdef COUNTER_TIMER_IRQ_EN
    ,
    output logic             irq_out
`endif
);

`ifdef COUNTER_TIMER_IRQ_EN
    localparam logic [CFG_W-1:0] CFG_WMASK = 5'h1f;
`else
    localparam logic [CFG_W-1:0] CFG_WMASK = 5'h0f;
`endif

    function automatic logic [REG_W-1:0] f_byte_wr(
        input logic [REG_W-1:0] old,
        input logic [REG_W-1:0] di,
        input logic [3:0]       we
    );
        logic [REG_W-1:0] v;
        v = old;
        for (int b = 0; b < 4; b++) begin
            if (we[b]) v[b*8 +: 8] = di[b*8 +: 8];
        end
        return v;
    endfunction

    logic [REG_W-1:0] r_count;
    logic [REG_W-1:0] r_data;
    logic [CFG_W-1:0] r_cfg;
    logic             r_term;

    logic             w_cnt_wr;
    logic             w_tick;
    logic             w_at_term;
    logic             w_term_hit;
    logic [REG_W-1:0] w_count_nxt;
    logic [CFG_W-1:0] w_cfg_nxt;

    assign w_cnt_wr  = |reg_val_we;
    assign w_tick    = r_cfg[CFG_EN] &
                       (r_cfg[CFG_CHAIN] ? chain_in : 1'b1);
    assign w_at_term = r_cfg[CFG_UPDOWN] ? (r_count == r_data)
                                         : (r_count == '0);
    // A CPU count write overrides the tick, including its terminal event.
    assign w_term_hit = w_tick & ~w_cnt_wr & w_at_term;

    always_comb begin
        w_count_nxt = r_count;
        if (w_cnt_wr) begin
            w_count_nxt = f_byte_wr(r_count, reg_val_di, reg_val_we);
        end else if (w_tick) begin
            if (w_at_term) begin
                if (!r_cfg[CFG_ONESHOT])
                    w_count_nxt = r_cfg[CFG_UPDOWN] ? '0 : r_data;
            end else begin
                w_count_nxt = r_cfg[CFG_UPDOWN] ? r_count + 32'd1
                                                : r_count - 32'd1;
            end
        end
    end

    always_comb begin
        w_cfg_nxt = r_cfg;
        if (w_term_hit && r_cfg[CFG_ONESHOT]) w_cfg_nxt[CFG_EN] = 1'b0;
        // An explicit config write wins over the one-shot self-disable.
        if (reg_cfg_we) w_cfg_nxt = reg_cfg_di & CFG_WMASK;
    end

    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
            r_data  <= '0;
            r_cfg   <= '0;
            r_term  <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_data  <= f_byte_wr(r_data, reg_dat_di, reg_dat_we);
            r_cfg   <= w_cfg_nxt;
            r_term  <= w_term_hit;
        end
    end

`ifdef COUNTER_TIMER_IRQ_EN
    logic r_irq;
    logic w_irq_clr;

    assign w_irq_clr = w_cnt_wr | (reg_cfg_we & ~reg_cfg_di[CFG_IRQEN]);

    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            r_irq <= 1'b0;
        end else if (w_irq_clr) begin
            r_irq <= 1'b0;
        end else if (w_term_hit && r_cfg[CFG_IRQEN]) begin
            r_irq <= 1'b1;
        end
    end

    assign irq_out = r_irq;
`endif

    assign reg_val_do = r_count;
    assign reg_dat_do = r_data;
    assign reg_cfg_do = r_cfg;
    assign term_out   = r_term;

endmodule

// File: tb/tb_caravel_counter_timer.sv
// Directed bench for caravel_counter_timer: two instances, the upper
// chained onto the lower's terminal pulse.
module tb_caravel_counter_timer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;

    logic [3:0]  lo_val_we = '0;
    logic [31:0] lo_val_di = '0;
    logic [31:0] lo_val_do;
    logic [3:0]  lo_dat_we = '0;
    logic [31:0] lo_dat_di = '0;
    logic [31:0] lo_dat_do;
    logic        lo_cfg_we = 1'b0;
    logic [4:0]  lo_cfg_di = '0;
    logic [4:0]  lo_cfg_do;
    logic        lo_term;

    logic [3:0]  hi_val_we = '0;
    logic [31:0] hi_val_di = '0;
    logic [31:0] hi_val_do;
    logic [3:0]  hi_dat_we = '0;
    logic [31:0] hi_dat_di = '0;
    logic [31:0] hi_dat_do;
    logic        hi_cfg_we = 1'b0;
    logic [4:0]  hi_cfg_di = '0;
    logic [4:0]  hi_cfg_do;
    logic        hi_term;

`ifdef COUNTER_TIMER_IRQ_EN
    logic lo_irq;
    logic hi_irq;
    localparam logic [31:0] UP_CFG_DONE = 32'h16;
`else
    localparam logic [31:0] UP_CFG_DONE = 32'h06;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_term   = 0;
    int t0;

    always #5 clk = ~clk;

    always @(posedge clk) if (lo_term) n_term++;

    caravel_counter_timer u_lo (
        .clkin      (clk),
        .resetn     (resetn),
        .reg_val_we (lo_val_we),
        .reg_val_di (lo_val_di),
        .reg_val_do (lo_val_do),
        .reg_dat_we (lo_dat_we),
        .reg_dat_di (lo_dat_di),
        .reg_dat_do (lo_dat_do),
        .reg_cfg_we (lo_cfg_we),
        .reg_cfg_di (lo_cfg_di),
        .reg_cfg_do (lo_cfg_do),
        .chain_in   (1'b0),
        .term_out   (lo_term)
`ifdef COUNTER_TIMER_IRQ_EN
        ,
        .irq_out    (lo_irq)
`endif
    );

    caravel_counter_timer u_hi (
        .clkin      (clk),
        .resetn     (resetn),
        .reg_val_we (hi_val_we),
        .reg_val_di (hi_val_di),
        .reg_val_do (hi_val_do),
        .reg_dat_we (hi_dat_we),
        .reg_dat_di (hi_dat_di),
        .reg_dat_do (hi_dat_do),
        .reg_cfg_we (hi_cfg_we),
        .reg_cfg_di (hi_cfg_di),
        .reg_cfg_do (hi_cfg_do),
        .chain_in   (lo_term),
        .term_out   (hi_term)
`ifdef COUNTER_TIMER_IRQ_EN
        ,
        .irq_out    (hi_irq)
`endif
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic lo_wr_val(input logic [3:0] we, input logic [31:0] d);
        lo_val_we = we; lo_val_di = d;
        step();
        lo_val_we = '0;
    endtask

    task automatic lo_wr_dat(input logic [3:0] we, input logic [31:0] d);
        lo_dat_we = we; lo_dat_di = d;
        step();
        lo_dat_we = '0;
    endtask

    task automatic lo_wr_cfg(input logic [4:0] d);
        lo_cfg_we = 1'b1; lo_cfg_di = d;
        step();
        lo_cfg_we = 1'b0;
    endtask

    task automatic hi_wr_val(input logic [31:0] d);
        hi_val_we = 4'hf; hi_val_di = d;
        step();
        hi_val_we = '0;
    endtask

    task automatic hi_wr_cfg(input logic [4:0] d);
        hi_cfg_we = 1'b1; hi_cfg_di = d;
        step();
        hi_cfg_we = 1'b0;
    endtask

    initial begin
        #3;
        check("rst_count", lo_val_do, 32'h0);
        check("rst_data", lo_dat_do, 32'h0);
        check("rst_cfg", {27'd0, lo_cfg_do}, 32'h0);
        check("rst_term", {31'd0, lo_term}, 32'h0);
`ifdef COUNTER_TIMER_IRQ_EN
        check("rst_irq", {31'd0, lo_irq}, 32'h0);
`endif
        @(posedge clk); #1;
        resetn = 1'b1;
        step();

        // Down / one-shot
        lo_wr_val(4'hf, 32'hdcba9876);
        lo_wr_cfg(5'h03);
        steps(32'h1b7b);
        check("dn_run", lo_val_do, 32'hdcba7cfb);
        lo_wr_val(4'hf, 32'h2);
        t0 = n_term;
        steps(2);
        check("dn_zero", lo_val_do, 32'h0);
        check("dn_noterm", {31'd0, lo_term}, 32'h0);
        step();
        check("dn_term", {31'd0, lo_term}, 32'h1);
        check("dn_en_clr", {27'd0, lo_cfg_do}, 32'h02);
        steps(5);
        check("dn_hold", lo_val_do, 32'h0);
        check("dn_pulses", n_term - t0, 1);

        // Up / one-shot with irq_en
        lo_wr_cfg(5'h00);
        lo_wr_val(4'hf, 32'h0);
        lo_wr_dat(4'hf, 32'h19);
        t0 = n_term;
        lo_wr_cfg(5'h17);
        steps(40);
        check("up_stop", lo_val_do, 32'h19);
        check("up_pulses", n_term - t0, 1);
        check("up_cfg", {27'd0, lo_cfg_do}, UP_CFG_DONE);
`ifdef COUNTER_TIMER_IRQ_EN
        check("up_irq", {31'd0, lo_irq}, 32'h1);
`endif
        lo_wr_val(4'hf, 32'h0);
`ifdef COUNTER_TIMER_IRQ_EN
        check("irq_clr", {31'd0, lo_irq}, 32'h0);
`endif

        // Down / continuous
        lo_wr_cfg(5'h00);
        lo_wr_dat(4'hf, 32'h0f);
        lo_wr_val(4'hf, 32'h0);
        lo_wr_cfg(5'h01);
        step();
        check("dc_reload", lo_val_do, 32'h0f);
        check("dc_term", {31'd0, lo_term}, 32'h1);
        step();
        check("dc_dec", lo_val_do, 32'h0e);
        steps(15);
        check("dc_reload2", lo_val_do, 32'h0f);
        check("dc_term2", {31'd0, lo_term}, 32'h1);
        lo_wr_cfg(5'h00);
        lo_wr_val(4'hf, 32'h0);
        lo_wr_cfg(5'h01);
        step();
        check("dc_rearm", lo_val_do, 32'h0f);

        // Chained 64-bit pair
        lo_wr_cfg(5'h00);
        hi_wr_val(32'h0a);
        hi_wr_cfg(5'h09);
        lo_wr_dat(4'hf, 32'h12bc);
        lo_wr_val(4'hf, 32'h0);
        lo_wr_cfg(5'h01);
        step();
        check("ch_lo_rl", lo_val_do, 32'h12bc);
        check("ch_hi_wait", hi_val_do, 32'h0a);
        step();
        check("ch_hi_1", hi_val_do, 32'h09);
        check("ch_lo_dec", lo_val_do, 32'h12bb);
        steps(32'h12bc);
        check("ch_lo_rl2", lo_val_do, 32'h12bc);
        check("ch_hi_hold", hi_val_do, 32'h09);
        step();
        check("ch_hi_2", hi_val_do, 32'h08);

        // Byte strobes
        lo_wr_cfg(5'h00);
        hi_wr_cfg(5'h00);
        lo_wr_val(4'hf, 32'h0);
        lo_wr_val(4'h1, 32'ha5b6c75d);
        check("bw_count", lo_val_do, 32'h0000005d);
        lo_wr_dat(4'hf, 32'h0);
        lo_wr_dat(4'h1, 32'h77777759);
        lo_wr_dat(4'h2, 32'h88880288);
        check("bw_data", lo_dat_do, 32'h00000259);

        // Reset mid-run
        lo_wr_dat(4'hf, 32'h100);
        lo_wr_val(4'hf, 32'h100);
        lo_wr_cfg(5'h01);
        steps(10);
        check("mr_run", lo_val_do, 32'hf6);
        #2 resetn = 1'b0;
        #1;
        check("mr_count", lo_val_do, 32'h0);
        check("mr_data", lo_dat_do, 32'h0);
        check("mr_cfg", {27'd0, lo_cfg_do}, 32'h0);
        check("mr_term", {31'd0, lo_term}, 32'h0);
        check("mr_hi", hi_val_do, 32'h0);
        step();
        resetn = 1'b1;
        t0 = n_term;
        steps(5);
        check("mr_idle", lo_val_do, 32'h0);
        check("mr_nopulse", n_term - t0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
